// File: rtl/vending_controller.sv
// Vending machine transaction sequencer: payment check, coin stock and revenue
// bookkeeping, greedy change planning and one-coin-at-a-time dispensing.
module vending_controller #(
  parameter int unsigned PRICE_1 = 50,
  parameter int unsigned PRICE_2 = 75,
  parameter int unsigned PRICE_3 = 100,
  parameter int unsigned INIT_Q  = 4,
  parameter int unsigned INIT_H  = 2,
  parameter int unsigned INIT_U  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        escolher,
  input  logic        inserir_dinheiro,
  input  logic        dar_troco,
  input  logic [7:0]  produto_escolhido,
  input  logic [7:0]  dinheiro_inserido,
  input  logic [23:0] moedas_inseridas,
  input  logic        moeda_ack,
  output logic        moeda_valid,
  output logic [1:0]  moeda_tipo,
  output logic [7:0]  troco_total,
  output logic        vendido,
  output logic        erro,
  output logic        ocupado,
  output logic [15:0] carteira,
  output logic [7:0]  estoque_q,
  output logic [7:0]  estoque_h,
  output logic [7:0]  estoque_u
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_PAID, S_PLAN, S_DISPENSE, S_REFUND} state_t;

  state_t      state_q, state_d;
  logic [9:0]  price_q, price_d, v_q, v_d;
  logic [7:0]  in25_q, in25_d, in50_q, in50_d, in100_q, in100_d;
  logic [7:0]  st25_q, st25_d, st50_q, st50_d, st100_q, st100_d;
  logic [7:0]  rm25_q, rm25_d, rm50_q, rm50_d, rm100_q, rm100_d;
  logic [7:0]  troco_q, troco_d;
  logic [15:0] cart_q, cart_d;
  logic        valid_q, valid_d, vend_q, vend_d, erro_q, erro_d;
  logic [1:0]  tipo_q, tipo_d;

  logic        code_ok;
  logic [9:0]  code_price, coin_val;
  logic [8:0]  sum25, sum50, sum100;
  logic        ovf;
  logic [7:0]  chg, n_u, n_h, n_q, rem1, rem2, rem3;
  logic [7:0]  r25, r50, r100;

  always_comb begin
    code_ok    = 1'b1;
    code_price = 10'(PRICE_1);
    case (produto_escolhido)
      8'd1:    code_price = 10'(PRICE_1);
      8'd2:    code_price = 10'(PRICE_2);
      8'd3:    code_price = 10'(PRICE_3);
      default: code_ok = 1'b0;
    endcase
  end

  // Coin value deliberately truncated to 10 bits before the compare.
  assign coin_val = {2'b0, moedas_inseridas[7:0]}   * 10'd25 +
                    {2'b0, moedas_inseridas[15:8]}  * 10'd50 +
                    {2'b0, moedas_inseridas[23:16]} * 10'd100;

  assign sum25  = {1'b0, st25_q}  + {1'b0, in25_q};
  assign sum50  = {1'b0, st50_q}  + {1'b0, in50_q};
  assign sum100 = {1'b0, st100_q} + {1'b0, in100_q};
  assign ovf    = sum25[8] | sum50[8] | sum100[8];

  // Greedy change plan; stock here already includes the coins just paid in.
  assign chg  = v_q[7:0] - price_q[7:0];
  assign n_u  = (chg / 8'd100 < st100_q) ? chg / 8'd100 : st100_q;
  assign rem1 = chg - n_u * 8'd100;
  assign n_h  = (rem1 / 8'd50 < st50_q) ? rem1 / 8'd50 : st50_q;
  assign rem2 = rem1 - n_h * 8'd50;
  assign n_q  = (rem2 / 8'd25 < st25_q) ? rem2 / 8'd25 : st25_q;
  assign rem3 = rem2 - n_q * 8'd25;

  always_comb begin
    state_d = state_q;  price_d = price_q;  v_d = v_q;
    in25_d  = in25_q;   in50_d  = in50_q;   in100_d = in100_q;
    st25_d  = st25_q;   st50_d  = st50_q;   st100_d = st100_q;
    rm25_d  = rm25_q;   rm50_d  = rm50_q;   rm100_d = rm100_q;
    troco_d = troco_q;  cart_d  = cart_q;
    valid_d = valid_q;  tipo_d  = tipo_q;
    vend_d  = 1'b0;     erro_d  = 1'b0;
    r25 = rm25_q;  r50 = rm50_q;  r100 = rm100_q;
    case (state_q)
      S_IDLE: begin
        if (escolher) begin
          if (code_ok) begin
            price_d = code_price;
            state_d = S_SEL;
          end else erro_d = 1'b1;
        end
      end
      S_SEL: begin
        if (inserir_dinheiro) begin
          if (coin_val == {2'b0, dinheiro_inserido}) begin
            in25_d  = moedas_inseridas[7:0];
            in50_d  = moedas_inseridas[15:8];
            in100_d = moedas_inseridas[23:16];
            v_d     = coin_val;
            state_d = S_PAID;
          end else erro_d = 1'b1;
        end else if (escolher) begin
          if (code_ok) price_d = code_price;
          else erro_d = 1'b1;
        end
      end
      S_PAID: begin
        if (dar_troco) begin
          if (v_q < price_q || ovf) begin
            erro_d  = ovf && !(v_q < price_q);
            troco_d = v_q[7:0];
            rm25_d  = in25_q;  rm50_d = in50_q;  rm100_d = in100_q;
            state_d = S_REFUND;
          end else begin
            st25_d  = sum25[7:0];  st50_d = sum50[7:0];  st100_d = sum100[7:0];
            state_d = S_PLAN;
          end
        end
      end
      S_PLAN: begin
        if (rem3 == 8'd0) begin
          st25_d  = st25_q - n_q;  st50_d = st50_q - n_h;  st100_d = st100_q - n_u;
          rm25_d  = n_q;  rm50_d = n_h;  rm100_d = n_u;
          cart_d  = cart_q + {6'b0, price_q};
          troco_d = chg;
          vend_d  = 1'b1;
          state_d = S_DISPENSE;
        end else begin
          st25_d  = st25_q - in25_q;  st50_d = st50_q - in50_q;  st100_d = st100_q - in100_q;
          rm25_d  = in25_q;  rm50_d = in50_q;  rm100_d = in100_q;
          troco_d = v_q[7:0];
          erro_d  = 1'b1;
          state_d = S_REFUND;
        end
      end
      S_DISPENSE, S_REFUND: begin
        if (!valid_q || moeda_ack) begin
          if (valid_q) begin
            case (tipo_q)
              2'b11:   r100 = rm100_q - 8'd1;
              2'b10:   r50  = rm50_q - 8'd1;
              default: r25  = rm25_q - 8'd1;
            endcase
          end
          rm25_d = r25;  rm50_d = r50;  rm100_d = r100;
          valid_d = 1'b1;
          if (r100 != 8'd0)      tipo_d = 2'b11;
          else if (r50 != 8'd0)  tipo_d = 2'b10;
          else if (r25 != 8'd0)  tipo_d = 2'b01;
          else begin
            valid_d = 1'b0;
            tipo_d  = 2'b00;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  price_q <= '0;  v_q <= '0;
      in25_q  <= '0;  in50_q <= '0;  in100_q <= '0;
      st25_q  <= 8'(INIT_Q);  st50_q <= 8'(INIT_H);  st100_q <= 8'(INIT_U);
      rm25_q  <= '0;  rm50_q <= '0;  rm100_q <= '0;
      troco_q <= '0;  cart_q <= '0;
      valid_q <= 1'b0;  tipo_q <= 2'b00;  vend_q <= 1'b0;  erro_q <= 1'b0;
    end else begin
      state_q <= state_d;  price_q <= price_d;  v_q <= v_d;
      in25_q  <= in25_d;  in50_q <= in50_d;  in100_q <= in100_d;
      st25_q  <= st25_d;  st50_q <= st50_d;  st100_q <= st100_d;
      rm25_q  <= rm25_d;  rm50_q <= rm50_d;  rm100_q <= rm100_d;
      troco_q <= troco_d;  cart_q <= cart_d;
      valid_q <= valid_d;  tipo_q <= tipo_d;  vend_q <= vend_d;  erro_q <= erro_d;
    end
  end

  assign moeda_valid = valid_q;
  assign moeda_tipo  = tipo_q;
  assign troco_total = troco_q;
  assign vendido     = vend_q;
  assign erro        = erro_q;
  assign ocupado     = (state_q != S_IDLE);
  assign carteira    = cart_q;
  assign estoque_q   = st25_q;
  assign estoque_h   = st50_q;
  assign estoque_u   = st100_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench: default-stock instance plus an instance with no 0,25/0,50
// coins in stock, both driven by the same strobes.
module tb_vending_controller;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        escolher, inserir_dinheiro, dar_troco, moeda_ack;
  logic [7:0]  produto_escolhido, dinheiro_inserido;
  logic [23:0] moedas_inseridas;

  logic        moeda_valid, vendido, erro, ocupado;
  logic [1:0]  moeda_tipo;
  logic [7:0]  troco_total, estoque_q, estoque_h, estoque_u;
  logic [15:0] carteira;

  logic        moeda_valid2, vendido2, erro2, ocupado2;
  logic [1:0]  moeda_tipo2;
  logic [7:0]  troco_total2, estoque_q2, estoque_h2, estoque_u2;
  logic [15:0] carteira2;

  int tests = 0, fails = 0;
  int vend_cnt = 0, err_cnt = 0, err_cnt2 = 0;
  logic [1:0] coins[$];
  logic [1:0] coins2[$];

  always #5 clock = ~clock;

  vending_controller dut (
    .clock(clock), .reset_n(reset_n), .escolher(escolher),
    .inserir_dinheiro(inserir_dinheiro), .dar_troco(dar_troco),
    .produto_escolhido(produto_escolhido), .dinheiro_inserido(dinheiro_inserido),
    .moedas_inseridas(moedas_inseridas), .moeda_ack(moeda_ack),
    .moeda_valid(moeda_valid), .moeda_tipo(moeda_tipo), .troco_total(troco_total),
    .vendido(vendido), .erro(erro), .ocupado(ocupado), .carteira(carteira),
    .estoque_q(estoque_q), .estoque_h(estoque_h), .estoque_u(estoque_u));

  vending_controller #(.INIT_Q(0), .INIT_H(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .escolher(escolher),
    .inserir_dinheiro(inserir_dinheiro), .dar_troco(dar_troco),
    .produto_escolhido(produto_escolhido), .dinheiro_inserido(dinheiro_inserido),
    .moedas_inseridas(moedas_inseridas), .moeda_ack(moeda_ack),
    .moeda_valid(moeda_valid2), .moeda_tipo(moeda_tipo2), .troco_total(troco_total2),
    .vendido(vendido2), .erro(erro2), .ocupado(ocupado2), .carteira(carteira2),
    .estoque_q(estoque_q2), .estoque_h(estoque_h2), .estoque_u(estoque_u2));

  always @(negedge clock) begin
    if (vendido) vend_cnt++;
    if (erro) err_cnt++;
    if (erro2) err_cnt2++;
    if (moeda_valid && moeda_ack) coins.push_back(moeda_tipo);
    if (moeda_valid2 && moeda_ack) coins2.push_back(moeda_tipo2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_sel(input logic [7:0] code);
    escolher = 1'b1; produto_escolhido = code;
    tick();
    escolher = 1'b0;
  endtask

  task automatic do_ins(input logic [7:0] amt, input logic [7:0] q, input logic [7:0] h,
                        input logic [7:0] u);
    inserir_dinheiro = 1'b1; dinheiro_inserido = amt; moedas_inseridas = {u, h, q};
    tick();
    inserir_dinheiro = 1'b0;
  endtask

  task automatic do_finish();
    dar_troco = 1'b1;
    tick();
    dar_troco = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (!ocupado && !ocupado2) break;
      moeda_ack = moeda_valid | moeda_valid2;
      tick();
    end
    moeda_ack = 1'b0;
    check("drain_done", {30'd0, ocupado, ocupado2}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, {moeda_valid, moeda_tipo, vendido, erro, ocupado}, 32'd0);
    check({tag, "_troco"}, {24'd0, troco_total}, 32'd0);
    check({tag, "_carteira"}, {16'd0, carteira}, 32'd0);
    check({tag, "_stock"}, {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd4, 8'd2, 8'd2});
    check({tag, "_stock2"}, {8'd0, estoque_q2, estoque_h2, estoque_u2}, {8'd0, 8'd0, 8'd0, 8'd2});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, e20;
    reset_n = 1'b0; escolher = 0; inserir_dinheiro = 0; dar_troco = 0; moeda_ack = 0;
    produto_escolhido = 0; dinheiro_inserido = 0; moedas_inseridas = 0;
    #22 reset_n = 1'b1;
    tick();
    check_reset_state("reset");

    // Sale of product 1 paid with 150: one R$1,00 coin back.
    coins.delete(); v0 = vend_cnt; e0 = err_cnt;
    do_sel(8'd1); do_ins(8'd150, 8'd0, 8'd1, 8'd1); do_finish(); drain();
    check("t1_vendido", vend_cnt - v0, 1);
    check("t1_erro", err_cnt - e0, 0);
    check("t1_ncoins", coins.size(), 1);
    if (coins.size() > 0) check("t1_coin0", {30'd0, coins[0]}, 32'd3);
    check("t1_troco", {24'd0, troco_total}, 32'd100);
    check("t1_carteira", {16'd0, carteira}, 32'd50);
    check("t1_stock", {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd4, 8'd3, 8'd2});

    // Product 2 paid with 100: one R$0,25 coin back.
    coins.delete(); v0 = vend_cnt;
    do_sel(8'd2); do_ins(8'd100, 8'd2, 8'd1, 8'd0); do_finish(); drain();
    check("t2_vendido", vend_cnt - v0, 1);
    check("t2_ncoins", coins.size(), 1);
    if (coins.size() > 0) check("t2_coin0", {30'd0, coins[0]}, 32'd1);
    check("t2_troco", {24'd0, troco_total}, 32'd25);
    check("t2_carteira", {16'd0, carteira}, 32'd125);
    check("t2_stock", {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd5, 8'd4, 8'd2});

    // Underpayment for product 3: refund 0,50 then 0,25.
    coins.delete(); v0 = vend_cnt;
    do_sel(8'd3); do_ins(8'd75, 8'd1, 8'd1, 8'd0); do_finish(); drain();
    check("t3_vendido", vend_cnt - v0, 0);
    check("t3_ncoins", coins.size(), 2);
    if (coins.size() > 1) begin
      check("t3_coin0", {30'd0, coins[0]}, 32'd2);
      check("t3_coin1", {30'd0, coins[1]}, 32'd1);
    end
    check("t3_troco", {24'd0, troco_total}, 32'd75);
    check("t3_carteira", {16'd0, carteira}, 32'd125);
    check("t3_stock", {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd5, 8'd4, 8'd2});

    // Rejected actions: invalid code in IDLE, mismatched amount in SEL.
    do_sel(8'd7);
    check("e_code_erro", {31'd0, erro}, 32'd1);
    check("e_code_idle", {31'd0, ocupado}, 32'd0);
    do_sel(8'd1);
    check("e_sel_ok", {30'd0, erro, ocupado}, 32'd1);
    do_ins(8'd150, 8'd1, 8'd0, 8'd1);
    check("e_ins_erro", {31'd0, erro}, 32'd1);
    check("e_ins_sel", {31'd0, ocupado}, 32'd1);
    coins.delete();
    do_ins(8'd150, 8'd0, 8'd1, 8'd1); do_finish(); drain();
    check("e_carteira", {16'd0, carteira}, 32'd175);
    check("e_stock", {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd5, 8'd5, 8'd2});

    // Ack held low: coin held stable; then reset mid-dispense.
    do_sel(8'd1); do_ins(8'd150, 8'd0, 8'd1, 8'd1); do_finish();
    for (int k = 0; k < 10; k++) begin
      if (moeda_valid) break;
      tick();
    end
    check("hold_valid_seen", {31'd0, moeda_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_stable", {29'd0, moeda_valid, moeda_tipo}, {29'd0, 1'b1, 2'b11});
    end
    reset_n = 1'b0;
    #2;
    check_reset_state("midreset");
    #1 reset_n = 1'b1;
    tick();
    check("midreset_idle", {31'd0, ocupado}, 32'd0);

    // Product 2 paid with one R$1,00: dut2 cannot make 25 and refunds.
    coins.delete(); coins2.delete(); v0 = vend_cnt; e0 = err_cnt; e20 = err_cnt2;
    do_sel(8'd2); do_ins(8'd100, 8'd0, 8'd0, 8'd1); do_finish(); drain();
    check("p2_erro", err_cnt2 - e20, 1);
    check("p2_ncoins", coins2.size(), 1);
    if (coins2.size() > 0) check("p2_coin0", {30'd0, coins2[0]}, 32'd3);
    check("p2_stock", {8'd0, estoque_q2, estoque_h2, estoque_u2}, {8'd0, 8'd0, 8'd0, 8'd2});
    check("p2_troco", {24'd0, troco_total2}, 32'd100);
    check("p2_carteira", {16'd0, carteira2}, 32'd0);
    check("p1_vendido", vend_cnt - v0, 1);
    check("p1_erro", err_cnt - e0, 0);
    check("p1_ncoins", coins.size(), 1);
    if (coins.size() > 0) check("p1_coin0", {30'd0, coins[0]}, 32'd1);
    check("p1_stock", {8'd0, estoque_q, estoque_h, estoque_u}, {8'd0, 8'd3, 8'd2, 8'd3});
    check("p1_carteira", {16'd0, carteira}, 32'd75);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Transaction sequencer for the vending machine.
- Takes the select / insert / give-change strobes, the product code, the inserted amount and the per-denomination coin counts.
- Checks payment against the product price and keeps the coin stock and revenue wallet (carteira).
- Plans change greedily from stock, then dispenses change or refunds coins one at a time over a valid/ack handshake.

Parameters:
- PRICE_1, 50, price of product 1 in centavos
- PRICE_2, 75, price of product 2 in centavos
- PRICE_3, 100, price of product 3 in centavos
- INIT_Q, 4, R$0,25 coins in stock after reset
- INIT_H, 2, R$0,50 coins in stock after reset
- INIT_U, 2, R$1,00 coins in stock after reset

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- escolher  in  1  select strobe, sampled when high
- inserir_dinheiro  in  1  insert strobe
- dar_troco  in  1  give-change (finish) strobe
- produto_escolhido  in  8  product code; only 1..3 are valid
- dinheiro_inserido  in  8  declared inserted amount in centavos
- moedas_inseridas  in  24  [7:0]=count of 0,25 coins, [15:8]=count of 0,50, [23:16]=count of 1,00
- moeda_ack  in  1  coin taken by dispenser
- moeda_valid  out  1  coin presented
- moeda_tipo  out  2  01=0,25; 10=0,50; 11=1,00; 00 when idle
- troco_total  out  8  change (or refund) amount of the last transaction, centavos
- vendido  out  1  one-cycle pulse on sale commit
- erro  out  1  one-cycle pulse on any rejected action or abort
- ocupado  out  1  high in every state except IDLE
- carteira  out  16  accumulated revenue in centavos, wraps mod 2^16
- estoque_q / estoque_h / estoque_u  out  8 each  coin stock per denomination

Behaviour:
- Reset (async assert, sync release): state IDLE; stock = INIT_*; carteira=0; all other outputs 0.
- Reset mid-transaction aborts it; inserted coins are neither kept nor refunded.
- IDLE:
  - escolher with code 1..3: latch price, go to SEL.
  - escolher with any other code: erro pulse, stay in IDLE.
  - inserir_dinheiro and dar_troco are ignored.
- SEL:
  - escolher with a valid code re-latches the price; an invalid code pulses erro and keeps the old price.
  - inserir_dinheiro: compute coin value V = 25q+50h+100u at 10-bit width.
  - If V == dinheiro_inserido (zero-extended), latch the counts and V, go to PAID.
  - Otherwise pulse erro and stay in SEL.
- PAID:
  - Further strobes other than dar_troco are ignored.
  - On dar_troco with V < price: troco_total=V, go to REFUND.
  - On dar_troco with V >= price: add the inserted counts to stock, go to PLAN.
  - If any stock+count > 255, skip the add, pulse erro and go to REFUND.
- PLAN (exactly 1 cycle):
  - C = V - price; troco_total=C.
  - Greedy plan: nU=min(C/100, stock_u); then nH from the remainder and stock_h; then nQ likewise.
  - Remainder 0: subtract nU/nH/nQ from stock, carteira += price, vendido pulse, go to DISPENSE.
  - Remainder nonzero: subtract the inserted counts back out of stock, erro pulse, troco_total=V, go to REFUND.
- DISPENSE / REFUND:
  - Both dispense a planned coin list, largest denomination first. REFUND uses the latched inserted counts.
  - First moeda_valid rises the cycle after entry.
  - moeda_tipo is held stable while moeda_valid && !moeda_ack.
  - A coin is consumed on moeda_valid && moeda_ack; the next coin is presented in the next cycle, with no gap.
  - After the last ack (or immediately if the list is empty): moeda_valid=0, go to IDLE.
  - No strobes are accepted during DISPENSE or REFUND.
- Simultaneous strobes: priority dar_troco > inserir_dinheiro > escolher, each valid only in its state.
- Widths: price and V are compared at 10 bits; C always fits in 8 bits because V <= 255.

Test Plan:
- Defaults; sequence escolher(prod 1), inserir(150; q0,h1,u1), dar_troco:
  - vendido pulses; one coin tipo 11 is dispensed; troco_total=100; carteira=50.
  - Stock ends q4, h3, u2.
- Continue with escolher(prod 2), inserir(100; q2,h1,u0), dar_troco:
  - One coin tipo 01; carteira=125; stock ends q5, h4, u2.
- Product 3 with inserir(75; q1,h1,u0), then dar_troco:
  - No vendido; refund of tipo 10 then tipo 01; troco_total=75; stock and carteira unchanged.
- INIT_Q=0, INIT_H=0; product 2 with inserir(100; u1):
  - Plan fails; erro pulses; tipo 11 is refunded; stock returns to q0, h0, u2.
- Product code 7, then inserir(150) with counts summing to 125:
  - Each pulses erro; state stays IDLE, then SEL respectively.
- moeda_ack held low 5 cycles during dispense, and separately reset_n pulsed mid-DISPENSE:
  - With ack low, moeda_valid and moeda_tipo stay stable.
  - On reset, all outputs return to their reset values and stock returns to INIT_*.
